// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, ALU/extender codes,
// mux selects, FSM states and the decoded-instruction/control-word types.
package multicycle_ctrl_pkg;

    localparam logic [5:0] INSTR_RTYPE      = 6'h00;
    localparam logic [5:0] INSTR_J          = 6'h02;
    localparam logic [5:0] INSTR_BEQ        = 6'h04;
    localparam logic [5:0] INSTR_ORI        = 6'h0D;
    localparam logic [5:0] INSTR_LUI        = 6'h0F;
    localparam logic [5:0] INSTR_LW         = 6'h23;
    localparam logic [5:0] INSTR_SW         = 6'h2B;
    localparam logic [5:0] INSTR_FUNCT_ADDU = 6'h21;
    localparam logic [5:0] INSTR_FUNCT_SUBU = 6'h23;

    localparam logic [4:0] ALUOP_ADD  = 5'b00000;
    localparam logic [4:0] ALUOP_ADDU = 5'b00001;
    localparam logic [4:0] ALUOP_SUBU = 5'b00011;
    localparam logic [4:0] ALUOP_OR   = 5'b00100;

    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGNED  = 2'd1;
    localparam logic [1:0] EXT_HIGHPOS = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StExecR  = 4'd3,
        StExecI  = 4'd4,
        StAluWb  = 4'd5,
        StMemAdr = 4'd6,
        StMemRd  = 4'd7,
        StMemWb  = 4'd8,
        StMemWr  = 4'd9,
        StBranch = 4'd10,
        StJump   = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        ClsRtypeAlu,
        ClsImmAlu,
        ClsLoad,
        ClsStore,
        ClsBeq,
        ClsJ,
        ClsIllegal
    } instr_class_e;

    typedef struct packed {
        instr_class_e cls;
        logic         alu_sub;   // R-type subu rather than addu
        logic         imm_high;  // lui rather than ori
    } decode_t;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_dst;
        logic       mem2reg;
        logic       reg_wr;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic [1:0] ext_op;
        logic [4:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class plus the
// two sub-variant flags the controller needs later in the sequence.
module mc_instr_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output decode_t    dec
);

    always_comb begin
        dec = '{cls: ClsIllegal, alu_sub: 1'b0, imm_high: 1'b0};
        case (opcode)
            INSTR_RTYPE: begin
                if (funct == INSTR_FUNCT_ADDU) begin
                    dec.cls = ClsRtypeAlu;
                end else if (funct == INSTR_FUNCT_SUBU) begin
                    dec.cls     = ClsRtypeAlu;
                    dec.alu_sub = 1'b1;
                end
            end
            INSTR_ORI: dec.cls = ClsImmAlu;
            INSTR_LUI: begin
                dec.cls      = ClsImmAlu;
                dec.imm_high = 1'b1;
            end
            INSTR_LW:  dec.cls = ClsLoad;
            INSTR_SW:  dec.cls = ClsStore;
            INSTR_BEQ: dec.cls = ClsBeq;
            INSTR_J:   dec.cls = ClsJ;
            default:   dec.cls = ClsIllegal;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the shared multi-cycle MIPS datapath.
// Optional MCTRL_MEMRDY_EN adds a mem_ready input that stalls the memory states.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
`ifdef MCTRL_MEMRDY_EN
    input  logic               mem_ready,
`endif
    output logic               pc_wr,
    output logic               pc_wr_cond,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               ir_wr,
    output logic               reg_dst,
    output logic               mem2reg,
    output logic               reg_wr,
    output logic               alu_srca,
    output logic [1:0]         alu_srcb,
    output logic [1:0]         ext_op,
    output logic [4:0]         alu_op,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] state_o
);

    state_e  state_q, state_d;
    decode_t dec, dec_q;
    ctrl_t   ctrl;
    logic    mem_go;

`ifdef MCTRL_MEMRDY_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    mc_instr_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    // Decode result is captured on leaving DECODE so later states depend only on registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dec_q   <= '{cls: ClsIllegal, alu_sub: 1'b0, imm_high: 1'b0};
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                dec_q <= dec;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (mem_go) state_d = StDecode;
            StDecode: begin
                unique case (dec.cls)
                    ClsRtypeAlu: state_d = StExecR;
                    ClsImmAlu:   state_d = StExecI;
                    ClsLoad,
                    ClsStore:    state_d = StMemAdr;
                    ClsBeq:      state_d = StBranch;
                    ClsJ:        state_d = StJump;
                    default:     state_d = StFetch;
                endcase
            end
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StMemAdr: state_d = (dec_q.cls == ClsStore) ? StMemWr : StMemRd;
            StMemRd:  if (mem_go) state_d = StMemWb;
            StMemWb:  state_d = StFetch;
            StMemWr:  if (mem_go) state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ctrl = '0;
        unique case (state_q)
            StIdle: ;
            StFetch: begin
                ctrl.mem_rd   = 1'b1;
                ctrl.ir_wr    = mem_go;
                ctrl.pc_wr    = mem_go;
                ctrl.alu_srca = 1'b0;
                ctrl.alu_srcb = SRCB_FOUR;
                ctrl.alu_op   = ALUOP_ADDU;
                ctrl.pc_src   = PCSRC_ALU;
            end
            StDecode: begin
                ctrl.alu_srca = 1'b0;
                ctrl.alu_srcb = SRCB_BRANCH;
                ctrl.ext_op   = EXT_SIGNED;
                ctrl.alu_op   = ALUOP_ADD;
                ctrl.illegal  = (dec.cls == ClsIllegal);
            end
            StExecR: begin
                ctrl.alu_srca = 1'b1;
                ctrl.alu_srcb = SRCB_RT;
                ctrl.alu_op   = dec_q.alu_sub ? ALUOP_SUBU : ALUOP_ADDU;
            end
            StExecI: begin
                ctrl.alu_srca = 1'b1;
                ctrl.alu_srcb = SRCB_IMM;
                ctrl.alu_op   = ALUOP_OR;
                ctrl.ext_op   = dec_q.imm_high ? EXT_HIGHPOS : EXT_ZERO;
            end
            StAluWb: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.mem2reg    = 1'b0;
                ctrl.reg_dst    = (dec_q.cls == ClsRtypeAlu);
                ctrl.instr_done = 1'b1;
            end
            StMemAdr: begin
                ctrl.alu_srca = 1'b1;
                ctrl.alu_srcb = SRCB_IMM;
                ctrl.ext_op   = EXT_SIGNED;
                ctrl.alu_op   = ALUOP_ADD;
            end
            StMemRd: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_wr     = 1'b1;
                ctrl.mem2reg    = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.instr_done = 1'b1;
            end
            StMemWr: begin
                ctrl.mem_wr     = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_go;
            end
            StBranch: begin
                ctrl.alu_srca   = 1'b1;
                ctrl.alu_srcb   = SRCB_RT;
                ctrl.alu_op     = ALUOP_SUBU;
                ctrl.pc_wr_cond = 1'b1;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            StJump: begin
                ctrl.pc_wr      = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_wr      = ctrl.pc_wr;
    assign pc_wr_cond = ctrl.pc_wr_cond;
    assign pc_src     = ctrl.pc_src;
    assign iord       = ctrl.iord;
    assign mem_rd     = ctrl.mem_rd;
    assign mem_wr     = ctrl.mem_wr;
    assign ir_wr      = ctrl.ir_wr;
    assign reg_dst    = ctrl.reg_dst;
    assign mem2reg    = ctrl.mem2reg;
    assign reg_wr     = ctrl.reg_wr;
    assign alu_srca   = ctrl.alu_srca;
    assign alu_srcb   = ctrl.alu_srcb;
    assign ext_op     = ctrl.ext_op;
    assign alu_op     = ctrl.alu_op;
    assign instr_done = ctrl.instr_done;
    assign illegal    = ctrl.illegal;
    assign state_o    = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle and
// checks state plus the full control word against hand-built expectations.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
`ifdef MCTRL_MEMRDY_EN
    logic       mem_ready;
`endif
    logic       pc_wr, pc_wr_cond, iord, mem_rd, mem_wr, ir_wr;
    logic       reg_dst, mem2reg, reg_wr, alu_srca, instr_done, illegal;
    logic [1:0] pc_src, alu_srcb, ext_op;
    logic [4:0] alu_op;
    logic [3:0] state_o;
    logic [22:0] obs;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
`ifdef MCTRL_MEMRDY_EN
        .mem_ready  (mem_ready),
`endif
        .pc_wr      (pc_wr),
        .pc_wr_cond (pc_wr_cond),
        .pc_src     (pc_src),
        .iord       (iord),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_wr      (ir_wr),
        .reg_dst    (reg_dst),
        .mem2reg    (mem2reg),
        .reg_wr     (reg_wr),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .ext_op     (ext_op),
        .alu_op     (alu_op),
        .instr_done (instr_done),
        .illegal    (illegal),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    assign obs = {pc_wr, pc_wr_cond, pc_src, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg,
                  reg_wr, alu_srca, alu_srcb, ext_op, alu_op, instr_done, illegal};

    function automatic logic [22:0] mk(
        input logic pw, input logic pwc, input logic [1:0] psrc, input logic io,
        input logic mr, input logic mw, input logic irw, input logic rd, input logic m2r,
        input logic rw, input logic sa, input logic [1:0] sb, input logic [1:0] ext,
        input logic [4:0] op, input logic done, input logic ill);
        return {pw, pwc, psrc, io, mr, mw, irw, rd, m2r, rw, sa, sb, ext, op, done, ill};
    endfunction

    task automatic check(input string tag, input state_e st, input logic [22:0] exp);
        total++;
        assert (state_o === st) else begin
            bad++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state_o, st);
        end
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s outputs: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag, input state_e st, input logic [22:0] exp);
        @(posedge clk);
        #1;
        check(tag, st, exp);
    endtask

    logic [22:0] v_zero, v_fetch, v_dec, v_dec_ill, v_ex_addu, v_ex_subu, v_ori, v_lui;
    logic [22:0] v_wb_r, v_wb_i, v_memadr, v_memrd, v_memwb, v_memwr, v_br, v_j;
`ifdef MCTRL_MEMRDY_EN
    logic [22:0] v_fetch_hold;
`endif

    initial begin
        v_zero    = '0;
        v_fetch   = mk(1, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'd0, 5'b00001, 0, 0);
        v_dec     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'd1, 5'b00000, 0, 0);
        v_dec_ill = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'd1, 5'b00000, 0, 1);
        v_ex_addu = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'd0, 5'b00001, 0, 0);
        v_ex_subu = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'd0, 5'b00011, 0, 0);
        v_ori     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'd0, 5'b00100, 0, 0);
        v_lui     = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'd2, 5'b00100, 0, 0);
        v_wb_r    = mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'd0, 5'b00000, 1, 0);
        v_wb_i    = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'd0, 5'b00000, 1, 0);
        v_memadr  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'd1, 5'b00000, 0, 0);
        v_memrd   = mk(0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 5'b00000, 0, 0);
        v_memwb   = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'd0, 5'b00000, 1, 0);
        v_memwr   = mk(0, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'd0, 5'b00000, 1, 0);
        v_br      = mk(0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'd0, 5'b00011, 1, 0);
        v_j       = mk(1, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'd0, 5'b00000, 1, 0);
`ifdef MCTRL_MEMRDY_EN
        v_fetch_hold = mk(0, 0, 2'b00, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'd0, 5'b00001, 0, 0);
        mem_ready = 1'b1;
`endif

        rst    = 1'b1;
        opcode = 6'h00;
        funct  = 6'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_idle", StIdle, v_zero);
        rst = 1'b0;
        tick("fetch_first", StFetch, v_fetch);

        // addu
        opcode = 6'h00; funct = 6'h21;
        tick("addu_dec", StDecode, v_dec);
        tick("addu_exec", StExecR, v_ex_addu);
        tick("addu_wb", StAluWb, v_wb_r);
        tick("addu_fetch", StFetch, v_fetch);

        // lw: 5 cycles
        opcode = 6'h23; funct = 6'h00;
        tick("lw_dec", StDecode, v_dec);
        tick("lw_adr", StMemAdr, v_memadr);
        tick("lw_rd", StMemRd, v_memrd);
        tick("lw_wb", StMemWb, v_memwb);
        tick("lw_fetch", StFetch, v_fetch);

        // sw: 4 cycles
        opcode = 6'h2B;
        tick("sw_dec", StDecode, v_dec);
        tick("sw_adr", StMemAdr, v_memadr);
        tick("sw_wr", StMemWr, v_memwr);
        tick("sw_fetch", StFetch, v_fetch);

        // beq: 3 cycles
        opcode = 6'h04;
        tick("beq_dec", StDecode, v_dec);
        tick("beq_br", StBranch, v_br);
        tick("beq_fetch", StFetch, v_fetch);

        // j: 3 cycles
        opcode = 6'h02;
        tick("j_dec", StDecode, v_dec);
        tick("j_jump", StJump, v_j);
        tick("j_fetch", StFetch, v_fetch);

        // subu
        opcode = 6'h00; funct = 6'h23;
        tick("subu_dec", StDecode, v_dec);
        tick("subu_exec", StExecR, v_ex_subu);
        tick("subu_wb", StAluWb, v_wb_r);
        tick("subu_fetch", StFetch, v_fetch);

        // ori
        opcode = 6'h0D; funct = 6'h00;
        tick("ori_dec", StDecode, v_dec);
        tick("ori_exec", StExecI, v_ori);
        tick("ori_wb", StAluWb, v_wb_i);
        tick("ori_fetch", StFetch, v_fetch);

        // lui
        opcode = 6'h0F;
        tick("lui_dec", StDecode, v_dec);
        tick("lui_exec", StExecI, v_lui);
        tick("lui_wb", StAluWb, v_wb_i);
`ifdef MCTRL_MEMRDY_EN
        mem_ready = 1'b0;
        tick("fetch_hold0", StFetch, v_fetch_hold);
        tick("fetch_hold1", StFetch, v_fetch_hold);
        tick("fetch_hold2", StFetch, v_fetch_hold);
        mem_ready = 1'b1;
        #1;
        check("fetch_ready", StFetch, v_fetch);
`else
        tick("lui_fetch", StFetch, v_fetch);
`endif

        // illegal opcode, then illegal R funct (add, not addu)
        opcode = 6'h3F;
        tick("ill_op_dec", StDecode, v_dec_ill);
        tick("ill_op_fetch", StFetch, v_fetch);
        opcode = 6'h00; funct = 6'h20;
        tick("ill_fn_dec", StDecode, v_dec_ill);
        tick("ill_fn_fetch", StFetch, v_fetch);

        // reset mid-lw aborts before writeback
        opcode = 6'h23; funct = 6'h00;
        tick("rlw_dec", StDecode, v_dec);
        tick("rlw_adr", StMemAdr, v_memadr);
        tick("rlw_rd", StMemRd, v_memrd);
        rst = 1'b1;
        tick("rlw_idle", StIdle, v_zero);
        rst = 1'b0;
        tick("rlw_fetch", StFetch, v_fetch);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
